// File: rtl/layer_color_mapper.sv
// Priority compositor for NUM_LAYERS palette-indexed layers with a shared runtime palette,
// frame-synchronous brightness and flash effects, and a fixed 3-cycle pixel pipeline.
module layer_color_mapper #(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 4,
  parameter int COORD_W      = 10,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_start,
  input  logic                        pix_en,
  input  logic [COORD_W-1:0]          DrawX,
  input  logic [COORD_W-1:0]          DrawY,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS-1:0]       flash_mask,
  input  logic [3:0]                  bright_in,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_data,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic [COORD_W-1:0]          out_X,
  output logic [COORD_W-1:0]          out_Y
);

  localparam int PAL_DEPTH = 1 << IDX_W;
  localparam int CNT_W     = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  // Frame-synchronous shadow state
  logic [3:0]            active_bright;
  logic [NUM_LAYERS-1:0] active_flash_mask;
  logic [CNT_W-1:0]      frame_cnt;
  logic                  flash_phase;

  logic [23:0]           pal [PAL_DEPTH];

  // Pipeline registers
  logic [IDX_W-1:0]      s1_idx;
  logic                  s1_flash;
  logic                  s1_valid;
  logic [COORD_W-1:0]    s1_x, s1_y;
  logic [23:0]           s2_color;
  logic                  s2_flash;
  logic                  s2_valid;
  logic [COORD_W-1:0]    s2_x, s2_y;

  logic [IDX_W-1:0]      win_idx;
  logic                  win_flash;
  logic [23:0]           s3_color;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  // Ascending scan: the last qualifying layer overwrites earlier ones, giving the highest k priority.
  always_comb begin
    win_idx   = '0;
    win_flash = 1'b0;
    if (layer_hit[0]) begin
      win_idx   = layer_idx[IDX_W-1:0];
      win_flash = active_flash_mask[0];
    end
    for (int k = 1; k < NUM_LAYERS; k++) begin
      if (layer_hit[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
        win_idx   = layer_idx[k*IDX_W +: IDX_W];
        win_flash = active_flash_mask[k];
      end
    end
  end

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] b);
    logic [11:0] p;
    p = {4'b0, c} * {8'b0, b};
    return p[10:3];
  endfunction

  assign s3_color = s2_flash ? 24'hFF_FFFF : s2_color;

  // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bright     <= 4'd8;
      active_flash_mask <= '0;
      frame_cnt         <= '0;
      flash_phase       <= 1'b0;
    end else if (frame_start) begin
      active_bright     <= (bright_in > 4'd8) ? 4'd8 : bright_in;
      active_flash_mask <= flash_mask;
      if (frame_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
        frame_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // NOTE: the palette is a small register file, so it is reset like any other flop;
  // a write lands at the edge, and a same-edge read still sees the old entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_idx    <= '0;
      s1_flash  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_color  <= '0;
      s2_flash  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      out_valid <= 1'b0;
      out_X     <= '0;
      out_Y     <= '0;
    end else begin
      s1_idx    <= win_idx;
      s1_flash  <= win_flash & flash_phase;
      s1_valid  <= pix_en;
      s1_x      <= DrawX;
      s1_y      <= DrawY;

      s2_color  <= pal[s1_idx];
      s2_flash  <= s1_flash;
      s2_valid  <= s1_valid;
      s2_x      <= s1_x;
      s2_y      <= s1_y;

      // Blanked pixels still carry their coordinates but drive black
      VGA_R     <= s2_valid ? scale(s3_color[23:16], active_bright) : 8'd0;
      VGA_G     <= s2_valid ? scale(s3_color[15:8],  active_bright) : 8'd0;
      VGA_B     <= s2_valid ? scale(s3_color[7:0],   active_bright) : 8'd0;
      out_valid <= s2_valid;
      out_X     <= s2_x;
      out_Y     <= s2_y;
    end
  end

endmodule

// File: tb/tb_layer_color_mapper.sv
// Scoreboard bench for layer_color_mapper: a behavioural model predicts each pixel when driven,
// and the prediction is compared against {out_valid, RGB, out_X, out_Y} three clocks later.
module tb_layer_color_mapper;

  localparam int NL      = 4;
  localparam int IW      = 4;
  localparam int CW      = 10;
  localparam int FF      = 2;
  localparam int OUT_W   = 1 + 24 + 2*CW;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_start;
  logic              pix_en;
  logic [CW-1:0]     DrawX, DrawY;
  logic [NL*IW-1:0]  layer_idx;
  logic [NL-1:0]     layer_hit;
  logic [NL-1:0]     flash_mask;
  logic [3:0]        bright_in;
  logic              pal_we;
  logic [IW-1:0]     pal_addr;
  logic [23:0]       pal_data;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              out_valid;
  logic [CW-1:0]     out_X, out_Y;

  layer_color_mapper #(
    .NUM_LAYERS(NL), .IDX_W(IW), .COORD_W(CW), .FLASH_FRAMES(FF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .layer_idx(layer_idx), .layer_hit(layer_hit),
    .flash_mask(flash_mask), .bright_in(bright_in), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .out_valid(out_valid), .out_X(out_X), .out_Y(out_Y)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [23:0]   m_pal [1 << IW];
  int            m_bright;
  logic [NL-1:0] m_mask;
  int            m_cnt;
  bit            m_phase;

  logic [OUT_W-1:0] exp_q [$];
  string            tag_q [$];
  string            cur_tag;
  logic [CW-1:0]    x_cnt = '0;
  logic [CW-1:0]    y_cnt = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp_v);
    end
  endtask

  function automatic logic [7:0] model_scale(input logic [7:0] c, input int b);
    int v;
    v = (int'(c) * b) / 8;
    return v[7:0];
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    logic [IW-1:0] idx;
    logic [IW-1:0] li;
    bit            fl;
    logic [23:0]   c;
    idx = '0;
    fl  = 0;
    for (int k = NL - 1; k >= 0; k--) begin
      li = layer_idx[k*IW +: IW];
      if (layer_hit[k] && (k == 0 || li != 0)) begin
        idx = li;
        fl  = m_phase && m_mask[k];
        break;
      end
    end
    c = fl ? 24'hFFFFFF : m_pal[idx];
    if (!pix_en) return {1'b0, 24'h0, DrawX, DrawY};
    return {1'b1, model_scale(c[23:16], m_bright), model_scale(c[15:8], m_bright),
            model_scale(c[7:0], m_bright), DrawX, DrawY};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << IW); i++) m_pal[i] = '0;
    m_bright = 8;
    m_mask   = '0;
    m_cnt    = 0;
    m_phase  = 0;
  endtask

  // One pixel clock: predict from the inputs now driven, advance the model, then compare
  // whatever prediction is now due at the outputs.
  task automatic tick();
    DrawX = x_cnt;
    DrawY = y_cnt;
    x_cnt = x_cnt + 1'b1;
    y_cnt = y_cnt + 10'd3;
    if (pal_we) m_pal[pal_addr] = pal_data;
    exp_q.push_back(model_out());
    tag_q.push_back(cur_tag);
    if (frame_start) begin
      m_bright = (bright_in > 8) ? 8 : int'(bright_in);
      m_mask   = flash_mask;
      if (m_cnt == FF - 1) begin
        m_cnt   = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    @(posedge Clk);
    #1;
    if (exp_q.size() == 3) begin
      check_eq(tag_q.pop_front(), 64'({out_valid, VGA_R, VGA_G, VGA_B, out_X, out_Y}),
               64'(exp_q.pop_front()));
    end
  endtask

  task automatic blank(input int n);
    pix_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [23:0] d);
    cur_tag  = "pal_write";
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    pix_en   = 1'b0;
    tick();
    pal_we   = 1'b0;
  endtask

  // Blank cycles around the pulse keep in-flight pixels clear of the new shadow values.
  task automatic frame(input logic [3:0] b, input logic [NL-1:0] fm);
    cur_tag = "frame_gap";
    blank(2);
    frame_start = 1'b1;
    bright_in   = b;
    flash_mask  = fm;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px(input string t, input logic [NL-1:0] hit, input logic [IW-1:0] i3,
                    input logic [IW-1:0] i2, input logic [IW-1:0] i1, input logic [IW-1:0] i0);
    cur_tag   = t;
    pix_en    = 1'b1;
    layer_hit = hit;
    layer_idx = {i3, i2, i1, i0};
    tick();
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_en      = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    layer_idx   = '0;
    layer_hit   = '0;
    flash_mask  = '0;
    bright_in   = 4'd8;
    pal_we      = 1'b0;
    pal_addr    = '0;
    pal_data    = '0;
    cur_tag     = "idle";
    model_reset();

    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_outputs", 64'({out_valid, VGA_R, VGA_G, VGA_B, out_X, out_Y}), 64'd0);
    Reset_n = 1'b1;

    // Palette writes then priority resolution
    wr(4'd1, 24'h112233);
    wr(4'd5, 24'hA0B0C0);
    frame(4'd8, '0);
    px("prio_l2_over_l0", 4'b0101, 4'd0, 4'd5, 4'd0, 4'd1);
    px("l2_transparent",  4'b0101, 4'd0, 4'd0, 4'd0, 4'd1);

    // Transparency and no-hit fall-through
    wr(4'd0, 24'h010203);
    px("no_hit",          4'b0000, 4'd7, 4'd5, 4'd3, 4'd1);
    px("l3_idx0_to_l0",   4'b1001, 4'd0, 4'd5, 4'd0, 4'd1);
    px("l3_idx0_only",    4'b1000, 4'd0, 4'd0, 4'd0, 4'd1);
    px("l0_idx0_opaque",  4'b0001, 4'd0, 4'd0, 4'd0, 4'd0);

    // Brightness scaling and saturation
    wr(4'd2, 24'hFF8001);
    frame(4'd4, '0);
    px("bright4",         4'b0010, 4'd0, 4'd0, 4'd2, 4'd0);
    bright_in = 4'd15;
    px("bright_no_frame", 4'b0010, 4'd0, 4'd0, 4'd2, 4'd0);
    frame(4'd15, '0);
    px("bright_sat",      4'b0010, 4'd0, 4'd0, 4'd2, 4'd0);
    frame(4'd0, '0);
    px("bright0",         4'b0010, 4'd0, 4'd0, 4'd2, 4'd0);

    // Flash on layer 1 across several frames; layer 2 must stay unaffected
    for (int f = 0; f < 6; f++) begin
      frame(4'd8, 4'b0010);
      px("flash_l1",      4'b0011, 4'd0, 4'd0, 4'd2, 4'd1);
      px("noflash_l2",    4'b0110, 4'd0, 4'd5, 4'd2, 4'd0);
    end
    frame(4'd6, 4'b0011);
    px("flash_bright6",   4'b0001, 4'd0, 4'd0, 4'd0, 4'd1);
    px("flash_bright6_b", 4'b0001, 4'd0, 4'd0, 4'd0, 4'd2);
    frame(4'd8, '0);

    // Blanking in a pixel stream
    for (int i = 0; i < 8; i++) begin
      px("blank_stream", 4'b0101, 4'd0, 4'd5, 4'd0, 4'd1);
      if (i == 3 || i == 4) begin
        pix_en = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      cur_tag   = "blank_stream2";
      pix_en    = (i != 2 && i != 3);
      layer_hit = 4'b0100;
      layer_idx = {4'd0, 4'd5, 4'd0, 4'd0};
      tick();
    end

    // Read-during-write: pixel reads idx 5 on the same edge that rewrites entry 5
    px("rdw_old",         4'b0100, 4'd0, 4'd5, 4'd0, 4'd0);
    cur_tag   = "rdw_write";
    pix_en    = 1'b1;
    pal_we    = 1'b1;
    pal_addr  = 4'd5;
    pal_data  = 24'h123456;
    tick();
    pal_we    = 1'b0;
    px("rdw_new",         4'b0100, 4'd0, 4'd5, 4'd0, 4'd0);

    // Random stream with writes interleaved
    for (int i = 0; i < 200; i++) begin
      cur_tag   = "random";
      pix_en    = ($urandom_range(0, 9) != 0);
      layer_hit = NL'($urandom);
      layer_idx = (NL*IW)'($urandom);
      pal_we    = ($urandom_range(0, 9) == 0);
      pal_addr  = IW'($urandom);
      pal_data  = 24'($urandom);
      tick();
    end
    pal_we = 1'b0;

    // Asynchronous reset mid-stream
    px("pre_reset",       4'b0001, 4'd0, 4'd0, 4'd0, 4'd2);
    px("pre_reset",       4'b0001, 4'd0, 4'd0, 4'd0, 4'd2);
    Reset_n = 1'b0;
    #1;
    check_eq("rst_async", 64'({out_valid, VGA_R, VGA_G, VGA_B, out_X, out_Y}), 64'd0);
    exp_q.delete();
    tag_q.delete();
    model_reset();
    @(posedge Clk);
    #1;
    check_eq("rst_held", 64'({out_valid, VGA_R, VGA_G, VGA_B, out_X, out_Y}), 64'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      px("post_reset_pal0", 4'b0111, 4'd0, 4'd5, 4'd2, 4'd1);
    end
    cur_tag = "drain";
    blank(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_color_mapper.md
# layer_color_mapper

Parametrised, pipelined successor to the single-sprite color mapper. It composites up to NUM_LAYERS palette-indexed layers per pixel by fixed priority and resolves the winner through a runtime-writable shared palette. It applies a per-frame global brightness and per-layer flash effect, then drives the VGA RGB outputs. It sits between the per-layer sprite/background index generators and the VGA controller, with a fixed 3-cycle pixel latency and delayed coordinates so downstream logic stays aligned.

## Interface
- NUM_LAYERS, 4: layer count; layer 0 is background, layer NUM_LAYERS-1 has highest priority.
- IDX_W, 4: palette index width; palette depth is 2**IDX_W entries of 24 bits.
- COORD_W, 10: DrawX/DrawY width.
- FLASH_FRAMES, 8: frames per flash half-period (≥1).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of each frame.
- pix_en  in  1  pixel active (not blanking).
- DrawX, DrawY  in  COORD_W each  current pixel coordinates.
- layer_idx  in  NUM_LAYERS*IDX_W  packed indices; layer k at bits [k*IDX_W +: IDX_W].
- layer_hit  in  NUM_LAYERS  layer k covers this pixel.
- flash_mask  in  NUM_LAYERS  layer k participates in flash.
- bright_in  in  4  requested brightness, 0..8; values above 8 saturate to 8.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IDX_W  palette write address.
- pal_data  in  24  {R,G,B} write data.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel color.
- out_valid  out  1  output pixel is active.
- out_X, out_Y  out  COORD_W each  coordinates aligned with VGA_*.

## Operation
- Layer select:
  - The winner is the highest k with layer_hit[k]=1 and a nonzero layer_idx for that layer. Index 0 is transparent on layers ≥1.
  - Layer 0 is opaque, and index 0 on layer 0 is a valid color.
  - If no layer qualifies, including layer_hit[0]=0, the result is index 0 with no flash.
- Palette: register array of 2**IDX_W × 24 bits, cleared to 0 on reset. Writes take effect on the Clk edge with pal_we=1. A read of the same address in that cycle returns the old data (read-first).
- Shadow registers, updated only on a cycle with frame_start=1 to prevent mid-frame tearing:
  - active_bright ← min(bright_in, 8).
  - active_flash_mask ← flash_mask.
- Flash:
  - frame_cnt counts frame_start pulses from 0 to FLASH_FRAMES-1 and wraps.
  - On wrap, flash_phase toggles.
  - When flash_phase=1 and the winning layer's bit is set in active_flash_mask, the color is forced to ff,ff,ff before brightness scaling.
- Brightness:
  - Each channel is computed as (c × active_bright) >> 3.
  - The 8×4 product is 12 bits; the output is bits [10:3].
  - bright=8 yields c exactly, bright=0 yields 0. No rounding.
- Blanking: pix_en=0 propagates down the pipeline and forces VGA_* = 0 and out_valid = 0 at the output.

## Timing
- Pipeline:
  - S1 registers winner index, flash flag, pix_en and coordinates.
  - S2 registers palette data.
  - S3 registers scaled RGB, out_valid, out_X and out_Y.
- Latency is 3 Clk from input to VGA_*, with throughput of one pixel per cycle and no stalls.
- frame_start takes effect on the shadow registers and the flash counter at the edge where it is sampled. Pixels already in S2/S3 use the new shadow values. A 1-pixel skew at frame start is accepted.
- Simultaneous frame_start and bright_in change: the value sampled on that edge is latched.
- Reset values:
  - VGA_R/G/B = 0, out_valid = 0, out_X/out_Y = 0.
  - Palette all 0, active_bright = 8, active_flash_mask = 0.
  - frame_cnt = 0, flash_phase = 0, all pipeline registers 0.
- Reset mid-frame clears everything immediately (asynchronous). The first valid output appears 3 Clk after release with pix_en=1.

## Test plan
- Palette write then priority:
  - Stimulus: write pal[1]=0x112233 and pal[5]=0xA0B0C0. Set layer 0 idx 1 and layer 2 idx 5, both hit, bright=8 latched by frame_start.
  - Required response: VGA = A0,B0,C0 exactly 3 cycles later.
  - Then set layer 2 idx 0; required response: VGA = 11,22,33.
- Transparency and no-hit:
  - All layer_hit=0 with pal[0]=0x010203 -> 01,02,03.
  - layer_hit[3]=1 with idx 0 only -> falls through to layer 0.
- Brightness:
  - pal entry 0xFF8001 with bright 4 latched -> 7F,40,00.
  - bright_in=15 -> saturates to 8 -> FF,80,01.
  - bright_in change without frame_start -> no effect.
- Flash with FLASH_FRAMES=2 and flash_mask[1]=1, layer 1 winning:
  - Frames 0–1 show the palette color.
  - Frames 2–3 show FF,FF,FF × bright.
  - Frame 4 reverts to the palette color.
  - Non-flash layers are unaffected.
- Blanking and alignment:
  - pix_en low for 2 cycles in a pixel stream -> VGA=0 and out_valid=0 on exactly those 2 output cycles.
  - out_X/out_Y equal the DrawX/DrawY from 3 cycles earlier.
- Read-during-write and reset:
  - Write to the address being read in the same cycle -> old color output.
  - Assert Reset_n=0 mid-stream -> all outputs 0 immediately; palette reads 0 after release.
